cast_expand_monitor: RTL and testbench
======================================

# cast_expand_monitor

Receive-side companion to the narrowing fixed-point cast in the correlator datapath. Takes a stream of narrow signed fixed-point samples, which may have been saturated upstream, and widens them losslessly to the accumulator format. It applies a per-frame power-of-two gain and counts samples sitting on either saturation rail. The per-frame clip count drives gain control and upstream headroom monitoring.

## Interface
- DIN_WIDTH, 16, input sample width (signed)
- DIN_POINT, 11, input fractional bits
- DOUT_WIDTH, 32, output sample width (signed)
- DOUT_POINT, 20, output fractional bits
- SHIFT_WIDTH, 3, width of gain exponent (gain = 2^shift, shift 0..2^SHIFT_WIDTH-1)
- FRAME_LEN, 1024, valid samples per frame
- CNT_WIDTH, 11, clip counter width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- din  in  DIN_WIDTH  input sample
- din_valid  in  1  input qualifier
- shift_in  in  SHIFT_WIDTH  requested gain exponent
- shift_load  in  1  capture shift_in into pending register
- dout  out  DOUT_WIDTH  widened, scaled sample
- dout_valid  out  1  output qualifier
- frame_sync  out  1  high with dout_valid on first sample of each frame
- clip_count  out  CNT_WIDTH  clipped-sample count of the last completed frame
- clip_valid  out  1  one-cycle pulse when clip_count updates

## Operation
- Elaboration checks (fatal): DOUT_POINT >= DIN_POINT; (DOUT_WIDTH-DOUT_POINT) >= (DIN_WIDTH-DIN_POINT) + 2^SHIFT_WIDTH - 1; 2^CNT_WIDTH > FRAME_LEN. Under these, the datapath never overflows or loses bits.
- Widening: sign-extend integer part, zero-fill DOUT_POINT-DIN_POINT LSBs, then arithmetic left shift by active_shift.
- Clip detect: din == {0,1...1} (positive rail) or din == {1,0...0} (negative rail). No other code counts.
- Frame counter: counts accepted samples (din_valid=1) 0..FRAME_LEN-1, then wraps to 0. Cycles with din_valid=0 change no state except shift_load capture.
- Clip counter: accumulates clip flags within the frame. On the last sample of a frame, clip_count loads the total including that sample. The internal counter then restarts at 0.
- Gain: shift_load writes pending_shift. active_shift <= pending_shift only when a sample with frame counter == 0 is accepted, so each frame uses a single gain.
- Simultaneous shift_load and first sample of a frame: the first sample sees the old pending value. The new value applies from the next frame.
- Multiple shift_load in one frame: the last one wins.

## Timing
- Two-stage pipeline, no backpressure. din_valid at cycle N gives dout_valid at N+2, and samples stay in order.
- Stage 1: register din, clip flag, frame position, and active_shift selection. Stage 2: shift/extend, output registers.
- frame_sync and clip_valid are aligned with the dout_valid of the first and last frame sample respectively.
- clip_count holds its value between pulses.
- Reset (rst_n low, async): dout=0, dout_valid=0, frame_sync=0, clip_count=0, clip_valid=0. Also active_shift=0, pending_shift=0, and both counters cleared.
- Reset mid-frame: the partial frame is discarded with no clip_valid pulse. The first sample after release is frame sample 0.
- After reset release, outputs respond normally from the first rising edge on which rst_n is high.

## Test plan
- Reset: drive random din/valid, assert rst_n low asynchronously between edges -> all outputs 0 immediately; after release, first accepted sample has frame_sync=1.
- Pass-through, shift 0: din 0x0800 (+1.0) -> dout 0x0010_0000 two cycles later; din 0xF800 (-1.0) -> 0xFFF0_0000; din 0x0001 -> 0x0000_0200.
- Gain, FRAME_LEN=8: load shift 3 at frame sample 2 -> samples 2..7 unchanged; next frame sample 0 of 0x0800 -> 0x0080_0000. Load shift 7 coincident with sample 0 -> applied one frame later. Full scale: 0x7FFF at shift 7 -> 0x7FFF_0000 (no overflow).
- Clip count, FRAME_LEN=8: three 0x7FFF, two 0x8000, one 0x8001, two zeros -> clip_count=5 with a single clip_valid pulse aligned to the 8th dout_valid. The next frame with no rail codes -> clip_count=0.
- Gappy input: din_valid random 30% duty over 3 frames -> frame_sync/clip_valid exactly once per 8 accepted samples, latency 2 on every sample, counts match a scoreboard.
- Reset at frame sample 5 -> no clip_valid; the next frame completes with a count covering only post-reset samples.

Source files
------------

// File: rtl/cast_expand_monitor_if.sv
// cast_expand_monitor_if
//   Sample bus between the narrow fixed-point source and the widening
//   monitor.
//
//   Handshake: valid-only streaming. din is consumed on every rising edge
//   where din_valid is 1; dout is meaningful on every rising edge where
//   dout_valid is 1. There is no ready signal and no backpressure.
//   shift_load is a single-cycle strobe that captures shift_in.
//
//   master : sample source (drives din/din_valid/shift_in/shift_load,
//            observes the results)
//   slave  : the monitor (consumes samples, produces dout/dout_valid,
//            frame_sync, clip_count, clip_valid)
interface cast_expand_monitor_if #(
  parameter int DIN_WIDTH   = 16,
  parameter int DOUT_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 3,
  parameter int CNT_WIDTH   = 11
);
  logic [DIN_WIDTH-1:0]   din;
  logic                   din_valid;
  logic [SHIFT_WIDTH-1:0] shift_in;
  logic                   shift_load;
  logic [DOUT_WIDTH-1:0]  dout;
  logic                   dout_valid;
  logic                   frame_sync;
  logic [CNT_WIDTH-1:0]   clip_count;
  logic                   clip_valid;

  modport master (
    output din, din_valid, shift_in, shift_load,
    input  dout, dout_valid, frame_sync, clip_count, clip_valid
  );

  modport slave (
    input  din, din_valid, shift_in, shift_load,
    output dout, dout_valid, frame_sync, clip_count, clip_valid
  );
endinterface

// File: rtl/cast_expand_monitor.sv
// cast_expand_monitor
//   Widens narrow signed fixed-point samples (DIN_WIDTH, DIN_POINT frac bits)
//   losslessly into the accumulator format (DOUT_WIDTH, DOUT_POINT frac bits),
//   applies a per-frame power-of-two gain, and counts samples sitting on
//   either saturation rail within each FRAME_LEN-sample frame.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cast_expand_monitor_if.slave
//            din/din_valid       input sample stream
//            shift_in/shift_load gain exponent, captured into a pending reg
//            dout/dout_valid     widened, scaled sample (2 cycles after din)
//            frame_sync          with dout_valid on the first frame sample
//            clip_count          rail count of the last completed frame
//            clip_valid          with dout_valid on the last frame sample
module cast_expand_monitor #(
  parameter int DIN_WIDTH   = 16,
  parameter int DIN_POINT   = 11,
  parameter int DOUT_WIDTH  = 32,
  parameter int DOUT_POINT  = 20,
  parameter int SHIFT_WIDTH = 3,
  parameter int FRAME_LEN   = 1024,
  parameter int CNT_WIDTH   = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cast_expand_monitor_if.slave    bus
);

  // Parameter sanity: these guarantee the datapath can neither overflow nor
  // drop bits, and that a full frame of clips fits in the counter.
  if (DOUT_POINT < DIN_POINT) begin : g_chk_point
    $fatal(1, "cast_expand_monitor: DOUT_POINT must be >= DIN_POINT");
  end
  if ((DOUT_WIDTH - DOUT_POINT) <
      (DIN_WIDTH - DIN_POINT) + (1 << SHIFT_WIDTH) - 1) begin : g_chk_int
    $fatal(1, "cast_expand_monitor: output integer part too narrow for max gain");
  end
  if ((longint'(1) << CNT_WIDTH) <= longint'(FRAME_LEN)) begin : g_chk_cnt
    $fatal(1, "cast_expand_monitor: CNT_WIDTH cannot hold FRAME_LEN");
  end

  localparam int unsigned            FRAC_SHIFT = DOUT_POINT - DIN_POINT;
  localparam logic [CNT_WIDTH-1:0]   LAST_POS   = CNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [DIN_WIDTH-1:0]   POS_RAIL   = {1'b0, {(DIN_WIDTH-1){1'b1}}};
  localparam logic [DIN_WIDTH-1:0]   NEG_RAIL   = {1'b1, {(DIN_WIDTH-1){1'b0}}};

  // Gain and frame bookkeeping. frame_pos fits in CNT_WIDTH because
  // 2^CNT_WIDTH > FRAME_LEN.
  logic [SHIFT_WIDTH-1:0] pending_shift;
  logic [SHIFT_WIDTH-1:0] active_shift;
  logic [CNT_WIDTH-1:0]   frame_pos;
  logic [CNT_WIDTH-1:0]   clip_acc;

  // Stage 1 registers
  logic                   s1_valid;
  logic [DIN_WIDTH-1:0]   s1_din;
  logic                   s1_first;
  logic                   s1_last;
  logic [SHIFT_WIDTH-1:0] s1_shift;
  logic [CNT_WIDTH-1:0]   s1_total;

  // Stage 1 combinational terms
  logic                   first_pos;
  logic                   last_pos;
  logic                   is_clip;
  logic [SHIFT_WIDTH-1:0] sample_shift;
  logic [CNT_WIDTH-1:0]   clip_total;

  // Stage 2 combinational terms
  logic [DOUT_WIDTH-1:0]  extended;
  logic [DOUT_WIDTH-1:0]  scaled;

  always_comb begin
    first_pos    = (frame_pos == '0);
    last_pos     = (frame_pos == LAST_POS);
    is_clip      = (bus.din == POS_RAIL) || (bus.din == NEG_RAIL);
    // The first sample of a frame already uses the gain it is latching;
    // a shift_load on that same edge only reaches pending_shift.
    sample_shift = first_pos ? pending_shift : active_shift;
    clip_total   = clip_acc + CNT_WIDTH'(is_clip);
  end

  always_comb begin
    extended = {{(DOUT_WIDTH-DIN_WIDTH){s1_din[DIN_WIDTH-1]}}, s1_din};
    // Left shifts are exact here: the integer headroom check above ensures
    // no significant bits reach the sign position.
    scaled   = (extended << FRAC_SHIFT) << s1_shift;
  end

  // Gain registers and stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_shift <= '0;
      active_shift  <= '0;
      frame_pos     <= '0;
      clip_acc      <= '0;
      s1_valid      <= 1'b0;
      s1_din        <= '0;
      s1_first      <= 1'b0;
      s1_last       <= 1'b0;
      s1_shift      <= '0;
      s1_total      <= '0;
    end else begin
      s1_valid <= bus.din_valid;
      if (bus.shift_load) begin
        pending_shift <= bus.shift_in;
      end
      if (bus.din_valid) begin
        frame_pos <= last_pos ? '0 : frame_pos + 1'b1;
        clip_acc  <= last_pos ? '0 : clip_total;
        if (first_pos) begin
          active_shift <= pending_shift;
        end
        s1_din   <= bus.din;
        s1_first <= first_pos;
        s1_last  <= last_pos;
        s1_shift <= sample_shift;
        s1_total <= clip_total;
      end
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.frame_sync <= 1'b0;
      bus.clip_valid <= 1'b0;
      bus.clip_count <= '0;
    end else begin
      bus.dout_valid <= s1_valid;
      bus.frame_sync <= s1_valid & s1_first;
      bus.clip_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        bus.dout <= scaled;
      end
      if (s1_valid && s1_last) begin
        bus.clip_count <= s1_total;
      end
    end
  end

endmodule

// File: tb/tb_cast_expand_monitor.sv
module tb_cast_expand_monitor;
  localparam int DIN_WIDTH   = 16;
  localparam int DIN_POINT   = 11;
  localparam int DOUT_WIDTH  = 32;
  localparam int DOUT_POINT  = 20;
  localparam int SHIFT_WIDTH = 3;
  localparam int FRAME_LEN   = 8;
  localparam int CNT_WIDTH   = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cast_expand_monitor_if #(
    .DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) bus ();

  cast_expand_monitor #(
    .DIN_WIDTH(DIN_WIDTH), .DIN_POINT(DIN_POINT),
    .DOUT_WIDTH(DOUT_WIDTH), .DOUT_POINT(DOUT_POINT),
    .SHIFT_WIDTH(SHIFT_WIDTH), .FRAME_LEN(FRAME_LEN), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0]           due;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  fs;
    logic                  cv;
    logic [CNT_WIDTH-1:0]  cc;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int m_idx;        // accepted samples so far in the current frame
  int m_clips;      // rail samples so far in the current frame
  int m_pending;
  int m_active;
  logic [CNT_WIDTH-1:0] hold_cc;  // clip_count the DUT should be showing

  task automatic model_reset();
    m_idx = 0; m_clips = 0; m_pending = 0; m_active = 0;
    hold_cc = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic ld, input logic [2:0] sh);
    exp_t e;
    longint val;
    if (v) begin
      if (m_idx == 0) m_active = m_pending;
      // value * 2^(frac difference) * 2^gain, in plain integer arithmetic
      val = longint'($signed(d)) * (longint'(1) << (DOUT_POINT - DIN_POINT + m_active));
      if (d == 16'h7FFF || d == 16'h8000) m_clips++;
      e.due  = cyc + 2;
      e.dout = val[DOUT_WIDTH-1:0];
      e.fs   = (m_idx == 0);
      e.cv   = (m_idx == FRAME_LEN - 1);
      e.cc   = e.cv ? CNT_WIDTH'(m_clips) : '0;
      if (e.cv) m_clips = 0;
      m_idx = (m_idx + 1) % FRAME_LEN;
      exp_q.push_back(e);
    end
    if (ld) m_pending = int'(sh);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic mon_en = 1'b0;
  logic [DOUT_WIDTH-1:0] obs_dout[$];
  logic [CNT_WIDTH-1:0]  obs_clip[$];
  int                    obs_clip_idx[$];
  int                    obs_fs;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && rst_n) begin
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q[0]);
        if (e.due < cyc) begin
          chk("latency", 64'(cyc), 64'(e.due));
          void'(exp_q.pop_front());
        end
      end
      e = '0;
      if (exp_q.size() > 0) e = exp_t'(exp_q[0]);
      if (exp_q.size() > 0 && e.due == cyc) begin
        void'(exp_q.pop_front());
        chk("dout_valid", 64'(bus.dout_valid), 64'd1);
        chk("dout", 64'(bus.dout), 64'(e.dout));
        chk("frame_sync", 64'(bus.frame_sync), 64'(e.fs));
        chk("clip_valid", 64'(bus.clip_valid), 64'(e.cv));
        if (e.cv) hold_cc = e.cc;
        chk("clip_count", 64'(bus.clip_count), 64'(hold_cc));
      end else begin
        chk("idle_dout_valid", 64'(bus.dout_valid), 64'd0);
        chk("idle_frame_sync", 64'(bus.frame_sync), 64'd0);
        chk("idle_clip_valid", 64'(bus.clip_valid), 64'd0);
      end
      if (bus.dout_valid) obs_dout.push_back(bus.dout);
      if (bus.dout_valid && bus.frame_sync) obs_fs++;
      if (bus.dout_valid && bus.clip_valid) begin
        obs_clip.push_back(bus.clip_count);
        obs_clip_idx.push_back(obs_dout.size() - 1);
      end
    end
  end

  task automatic clear_obs();
    obs_dout.delete(); obs_clip.delete(); obs_clip_idx.delete(); obs_fs = 0;
  endtask

  function automatic logic [DOUT_WIDTH-1:0] obs_at(input int i);
    if (i < obs_dout.size()) return obs_dout[i];
    return 32'hDEAD_BEEF;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic v, input logic [15:0] d, input logic ld, input logic [2:0] sh);
    @(posedge clk); #1;
    bus.din_valid  = v;
    bus.din        = d;
    bus.shift_load = ld;
    bus.shift_in   = sh;
    model_step(v, d, ld, sh);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 16'h0, 1'b0, 3'd0);
  endtask

  // Asynchronous reset asserted between edges, outputs checked before the
  // next edge arrives.
  task automatic do_reset();
    @(posedge clk); #1;
    bus.din        = 16'($urandom);
    bus.din_valid  = 1'($urandom_range(0, 1));
    bus.shift_load = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
    chk("rst_frame_sync", 64'(bus.frame_sync), 64'd0);
    chk("rst_clip_count", 64'(bus.clip_count), 64'd0);
    chk("rst_clip_valid", 64'(bus.clip_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.din_valid = 1'b0;
    mon_en = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]            shift;
    logic [15:0]           din;
    logic [DOUT_WIDTH-1:0] exp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int acc;
    int budget;
    int r;
    logic v;
    logic [15:0] d;

    vecs[0] = '{3'd0, 16'h0800, 32'h0010_0000};
    vecs[1] = '{3'd0, 16'hF800, 32'hFFF0_0000};
    vecs[2] = '{3'd0, 16'h0001, 32'h0000_0200};
    vecs[3] = '{3'd3, 16'h0800, 32'h0080_0000};
    vecs[4] = '{3'd7, 16'h7FFF, 32'h7FFF_0000};
    vecs[5] = '{3'd7, 16'h8000, 32'h8000_0000};
    vecs[6] = '{3'd2, 16'hFFFF, 32'hFFFF_F800};
    vecs[7] = '{3'd0, 16'h0000, 32'h0000_0000};

    bus.din = '0; bus.din_valid = 1'b0; bus.shift_in = '0; bus.shift_load = 1'b0;
    model_reset();
    clear_obs();
    repeat (2) @(posedge clk);

    // Single-sample vectors: gain loaded while idle, applied to frame sample 0.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      send(1'b0, 16'h0, 1'b1, vecs[i].shift);
      send(1'b1, vecs[i].din, 1'b0, 3'd0);
      send(1'b0, 16'h0, 1'b0, 3'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 64'(bus.dout_valid), 64'd1);
      chk($sformatf("vec%0d_dout", i), 64'(bus.dout), 64'(vecs[i].exp));
    end

    // Gain timing: mid-frame load waits for the next frame; a load on
    // sample 0 waits one more frame.
    do_reset();
    clear_obs();
    for (int i = 0; i < FRAME_LEN; i++) send(1'b1, 16'h0800, i == 2, 3'd3);
    for (int i = 0; i < FRAME_LEN; i++) send(1'b1, 16'h0800, 1'b0, 3'd0);
    for (int i = 0; i < FRAME_LEN; i++) send(1'b1, 16'h0800, i == 0, 3'd7);
    send(1'b1, 16'h0800, 1'b0, 3'd0);
    send(1'b1, 16'h7FFF, 1'b0, 3'd0);
    idle(4);
    chk("gain_s2_unchanged", 64'(obs_at(2)), 64'h0010_0000);
    chk("gain_s7_unchanged", 64'(obs_at(7)), 64'h0010_0000);
    chk("gain_next_frame", 64'(obs_at(8)), 64'h0080_0000);
    chk("gain_coincident_old", 64'(obs_at(16)), 64'h0080_0000);
    chk("gain_coincident_new", 64'(obs_at(24)), 64'h0800_0000);
    chk("gain_full_scale", 64'(obs_at(25)), 64'h7FFF_0000);

    // Clip counting over two frames.
    do_reset();
    clear_obs();
    send(1'b1, 16'h7FFF, 1'b0, 3'd0);
    send(1'b1, 16'h7FFF, 1'b0, 3'd0);
    send(1'b1, 16'h7FFF, 1'b0, 3'd0);
    send(1'b1, 16'h8000, 1'b0, 3'd0);
    send(1'b1, 16'h8000, 1'b0, 3'd0);
    send(1'b1, 16'h8001, 1'b0, 3'd0);
    send(1'b1, 16'h0000, 1'b0, 3'd0);
    send(1'b1, 16'h0000, 1'b0, 3'd0);
    for (int i = 0; i < FRAME_LEN; i++) send(1'b1, 16'(i * 100 + 1), 1'b0, 3'd0);
    idle(4);
    chk("clip_pulses", 64'(obs_clip.size()), 64'd2);
    if (obs_clip.size() == 2) begin
      chk("clip_frame0_count", 64'(obs_clip[0]), 64'd5);
      chk("clip_frame0_pos", 64'(obs_clip_idx[0]), 64'd7);
      chk("clip_frame1_count", 64'(obs_clip[1]), 64'd0);
      chk("clip_frame1_pos", 64'(obs_clip_idx[1]), 64'd15);
    end
    chk("clip_hold", 64'(bus.clip_count), 64'd0);

    // Reset after frame sample 5: partial frame dropped.
    do_reset();
    clear_obs();
    send(1'b1, 16'h7FFF, 1'b0, 3'd0);
    send(1'b1, 16'h8000, 1'b0, 3'd0);
    send(1'b1, 16'h0001, 1'b0, 3'd0);
    send(1'b1, 16'h0002, 1'b0, 3'd0);
    send(1'b1, 16'h0003, 1'b0, 3'd0);
    do_reset();
    chk("midrst_no_pulse", 64'(obs_clip.size()), 64'd0);
    for (int i = 0; i < FRAME_LEN; i++) send(1'b1, (i == 3) ? 16'h8000 : 16'h0100, 1'b0, 3'd0);
    idle(4);
    chk("midrst_pulses", 64'(obs_clip.size()), 64'd1);
    if (obs_clip.size() == 1) chk("midrst_count", 64'(obs_clip[0]), 64'd1);
    chk("midrst_frame_syncs", 64'(obs_fs), 64'd2);

    // Gappy random traffic, ~30% duty, three frames.
    do_reset();
    clear_obs();
    acc = 0;
    budget = 0;
    while (acc < 3 * FRAME_LEN && budget < 2000) begin
      v = ($urandom_range(0, 99) < 30);
      r = $urandom_range(0, 7);
      d = (r == 0) ? 16'h7FFF : (r == 1) ? 16'h8000 : 16'($urandom);
      send(v, d, ($urandom_range(0, 9) == 0), 3'($urandom));
      if (v) acc++;
      budget++;
    end
    chk("gappy_budget", 64'(acc), 64'(3 * FRAME_LEN));
    idle(4);
    chk("gappy_frame_syncs", 64'(obs_fs), 64'd3);
    chk("gappy_clip_pulses", 64'(obs_clip.size()), 64'd3);
    chk("gappy_sample_count", 64'(obs_dout.size()), 64'(3 * FRAME_LEN));
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
